// File: rtl/fault_latch_sequencer.sv
// Fault-latch controller: sync/debounce of raw faults, sticky latches,
// first-fault capture, lamp-test window and clear handshake.
module fault_latch_sequencer #(
   parameter int N_FAULTS         = 8,
   parameter int DEBOUNCE_CYCLES  = 16,
   parameter int LAMP_TEST_CYCLES = 1000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_FAULTS-1:0]         fault_in,
   input  logic                        clear_req,
   input  logic                        lamp_test_req,
   output logic [N_FAULTS-1:0]         fault_latched,
   output logic                        fault_out,
   output logic [$clog2(N_FAULTS)-1:0] first_fault_idx,
   output logic                        first_fault_valid,
   output logic                        la_test,
   output logic                        clear_ack,
   output logic                        clear_nack,
   output logic                        busy
);

   localparam int IW  = $clog2(N_FAULTS);
   localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LCW = $clog2(LAMP_TEST_CYCLES + 1);

   typedef enum logic [1:0] {RUN, LAMP_TEST, CLEAR} state_e;

   state_e                state_q, state_d;
   logic [N_FAULTS-1:0]   s1_q, s2_q;
   logic [CW-1:0]         cnt_q [N_FAULTS];
   logic [CW-1:0]         cnt_d [N_FAULTS];
   logic [N_FAULTS-1:0]   lat_q, lat_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  val_q, val_d;
   logic                  la_q, la_d;
   logic                  ack_q, ack_d;
   logic                  nack_q, nack_d;
   logic                  clr_prev_q, lt_prev_q;
   logic [LCW-1:0]        lcnt_q, lcnt_d;

   logic [N_FAULTS-1:0]   qual, newb, base_lat;
   logic [IW-1:0]         lo_idx, base_idx;
   logic                  base_val, idle, clearing;
   logic                  clr_rise, lt_rise;

   assign clr_rise = clear_req & ~clr_prev_q;
   assign lt_rise  = lamp_test_req & ~lt_prev_q;

   always_comb begin
      idle = (s2_q == '0);
      for (int i = 0; i < N_FAULTS; i++) begin
         qual[i]  = (cnt_q[i] == CW'(DEBOUNCE_CYCLES));
         cnt_d[i] = '0;
         if (s2_q[i])
            cnt_d[i] = qual[i] ? cnt_q[i] : cnt_q[i] + CW'(1);
         if (cnt_q[i] != '0)
            idle = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      la_d     = la_q;
      lcnt_d   = lcnt_q;
      ack_d    = 1'b0;
      nack_d   = 1'b0;
      clearing = 1'b0;
      unique case (state_q)
         RUN: begin
            if (lt_rise) begin
               state_d = LAMP_TEST;
               la_d    = 1'b1;
               lcnt_d  = LCW'(1);
               nack_d  = clr_rise;
            end else if (clr_rise) begin
               if (idle) state_d = CLEAR;
               else      nack_d  = 1'b1;
            end
         end
         LAMP_TEST: begin
            nack_d = clr_rise;
            if (lcnt_q == LCW'(LAMP_TEST_CYCLES)) begin
               state_d = RUN;
               la_d    = 1'b0;
            end else begin
               lcnt_d = lcnt_q + LCW'(1);
            end
         end
         CLEAR: begin
            clearing = 1'b1;
            ack_d    = 1'b1;
            state_d  = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // A qualification on the clear edge survives: set wins over clear.
   always_comb begin
      base_lat = clearing ? '0 : lat_q;
      base_val = clearing ? 1'b0 : val_q;
      base_idx = clearing ? '0 : idx_q;
      lat_d    = base_lat | qual;
      newb     = qual & ~base_lat;
      lo_idx   = '0;
      for (int i = N_FAULTS - 1; i >= 0; i--)
         if (newb[i]) lo_idx = IW'(i);
      idx_d = base_idx;
      val_d = base_val;
      if (!base_val && (newb != '0)) begin
         idx_d = lo_idx;
         val_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         s1_q       <= '0;
         s2_q       <= '0;
         lat_q      <= '0;
         idx_q      <= '0;
         val_q      <= 1'b0;
         la_q       <= 1'b0;
         ack_q      <= 1'b0;
         nack_q     <= 1'b0;
         clr_prev_q <= 1'b0;
         lt_prev_q  <= 1'b0;
         lcnt_q     <= '0;
         for (int i = 0; i < N_FAULTS; i++) cnt_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         s1_q       <= fault_in;
         s2_q       <= s1_q;
         lat_q      <= lat_d;
         idx_q      <= idx_d;
         val_q      <= val_d;
         la_q       <= la_d;
         ack_q      <= ack_d;
         nack_q     <= nack_d;
         clr_prev_q <= clear_req;
         lt_prev_q  <= lamp_test_req;
         lcnt_q     <= lcnt_d;
         for (int i = 0; i < N_FAULTS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign fault_latched     = lat_q;
   assign fault_out         = |lat_q;
   assign first_fault_idx   = idx_q;
   assign first_fault_valid = val_q;
   assign la_test           = la_q;
   assign clear_ack         = ack_q;
   assign clear_nack        = nack_q;
   assign busy              = (state_q != RUN);

endmodule

// File: tb/tb_fault_latch_sequencer.sv
// Bench for fault_latch_sequencer: directed plan with literal checks plus
// random traffic against a sample-history reference model.
module tb_fault_latch_sequencer;

   localparam int N  = 8;
   localparam int DB = 4;
   localparam int LT = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [N-1:0]  fault_in = '0;
   logic          clear_req = 1'b0;
   logic          lamp_test_req = 1'b0;
   logic [N-1:0]  fault_latched;
   logic          fault_out;
   logic [IW-1:0] first_fault_idx;
   logic          first_fault_valid;
   logic          la_test;
   logic          clear_ack;
   logic          clear_nack;
   logic          busy;

   fault_latch_sequencer #(
      .N_FAULTS(N), .DEBOUNCE_CYCLES(DB), .LAMP_TEST_CYCLES(LT)
   ) dut (
      .clk(clk), .reset(reset), .fault_in(fault_in),
      .clear_req(clear_req), .lamp_test_req(lamp_test_req),
      .fault_latched(fault_latched), .fault_out(fault_out),
      .first_fault_idx(first_fault_idx),
      .first_fault_valid(first_fault_valid),
      .la_test(la_test), .clear_ack(clear_ack),
      .clear_nack(clear_nack), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: hq[j] is the fault_in sample taken j edges ago.
   logic [N-1:0]  hq[$];
   logic [N-1:0]  m_lat = '0;
   logic [IW-1:0] m_idx = '0;
   bit            m_val, m_la, m_ack, m_nack, m_busy;
   bit            m_pclr, m_plt, clr_pend;
   int            lt_left;

   always @(posedge clk or negedge reset) begin
      logic [N-1:0] qual, base, newb;
      bit crise, lrise, idle, bval;
      if (!reset) begin
         hq = {};
         for (int j = 0; j < DB + 3; j++) hq.push_back('0);
         m_lat = '0; m_idx = '0; m_val = 0; m_la = 0;
         m_ack = 0; m_nack = 0; m_busy = 0;
         m_pclr = 0; m_plt = 0; clr_pend = 0; lt_left = 0;
      end else begin
         hq.push_front(fault_in);
         void'(hq.pop_back());
         qual = '1;
         for (int j = 3; j <= DB + 2; j++) qual &= hq[j];
         idle  = ((hq[2] | hq[3]) == '0);
         crise = clear_req && !m_pclr;
         lrise = lamp_test_req && !m_plt;
         m_pclr = clear_req;
         m_plt  = lamp_test_req;
         m_ack = 0; m_nack = 0;
         base = m_lat; bval = m_val;
         if (clr_pend) begin
            base = '0; bval = 0; m_idx = '0; m_ack = 1;
         end
         newb  = qual & ~base;
         m_lat = base | qual;
         m_val = bval;
         if (!bval && newb != '0) begin
            for (int i = 0; i < N; i++)
               if (newb[i]) begin m_idx = IW'(i); break; end
            m_val = 1;
         end
         if (clr_pend) clr_pend = 0;
         else if (lt_left > 0) begin
            if (crise) m_nack = 1;
            lt_left--;
         end else if (lrise) begin
            lt_left = LT;
            if (crise) m_nack = 1;
         end else if (crise) begin
            if (idle) clr_pend = 1;
            else m_nack = 1;
         end
         m_la   = (lt_left > 0);
         m_busy = (lt_left > 0) || clr_pend;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("latched", 32'(fault_latched), 32'(m_lat));
         chk("fault_out", 32'(fault_out), 32'(m_lat != '0));
         chk("ff_valid", 32'(first_fault_valid), 32'(m_val));
         if (m_val) chk("ff_idx", 32'(first_fault_idx), 32'(m_idx));
         chk("la_test", 32'(la_test), 32'(m_la));
         chk("clear_ack", 32'(clear_ack), 32'(m_ack));
         chk("clear_nack", 32'(clear_nack), 32'(m_nack));
         chk("busy", 32'(busy), 32'(m_busy));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk); #2 reset = 1'b0;
      @(negedge clk); #2 reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic count_la(input string nm, input int exp);
      int c = 0;
      for (int i = 0; i < LT + 4; i++) begin
         step(1);
         if (la_test) c++;
      end
      chk(nm, 32'(c), 32'(exp));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] hold;
      step(2);
      #2 reset = 1'b1;
      chk_en = 1'b1;
      step(20);
      chk("reset_latched", 32'(fault_latched), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_la", 32'(la_test), 32'h0);

      fault_in[5] = 1'b1; step(3);
      fault_in[5] = 1'b0; step(8);
      chk("short_pulse", 32'(fault_latched), 32'h0);
      fault_in[5] = 1'b1; step(6);
      chk("lat5_early", 32'(fault_latched), 32'h0);
      step(1);
      chk("lat5", 32'(fault_latched), 32'h20);
      chk("lat5_idx", 32'(first_fault_idx), 32'd5);
      chk("lat5_out", 32'(fault_out), 32'h1);

      fault_in = '0;
      pulse_reset();
      fault_in = 8'h44; step(7);
      chk("lat44", 32'(fault_latched), 32'h44);
      chk("lat44_idx", 32'(first_fault_idx), 32'd2);
      fault_in = 8'h45; step(7);
      chk("lat45", 32'(fault_latched), 32'h45);
      chk("lat45_idx", 32'(first_fault_idx), 32'd2);

      fault_in = 8'h40; clear_req = 1'b1; step(1);
      chk("nack", 32'(clear_nack), 32'h1);
      step(1);
      chk("nack_end", 32'(clear_nack), 32'h0);
      chk("nack_keep", 32'(fault_latched), 32'h45);
      clear_req = 1'b0; fault_in = '0; step(5);
      clear_req = 1'b1; step(1);
      chk("clr_busy", 32'(busy), 32'h1);
      step(1);
      chk("clr_ack", 32'(clear_ack), 32'h1);
      chk("clr_busy_end", 32'(busy), 32'h0);
      chk("clr_lat", 32'(fault_latched), 32'h0);
      chk("clr_val", 32'(first_fault_valid), 32'h0);
      clear_req = 1'b0; step(2);

      lamp_test_req = 1'b1; fault_in = 8'h02;
      begin
         int c = 0;
         for (int i = 1; i <= LT + 4; i++) begin
            step(1);
            if (la_test) c++;
            if (i == 1) chk("lt_busy", 32'(busy), 32'h1);
            if (i == 3) clear_req = 1'b1;
            if (i == 4) chk("lt_nack", 32'(clear_nack), 32'h1);
            if (i == 7) chk("lt_lat1", 32'(fault_latched), 32'h02);
         end
         chk("lt_len", 32'(c), 32'(LT));
      end
      lamp_test_req = 1'b0; clear_req = 1'b0; fault_in = '0; step(5);
      clear_req = 1'b1; step(3);
      clear_req = 1'b0;
      chk("clr2_lat", 32'(fault_latched), 32'h0);
      fault_in = 8'h10; step(7);
      chk("lat10", 32'(fault_latched), 32'h10);
      lamp_test_req = 1'b1; step(4);
      chk("lt4_la", 32'(la_test), 32'h1);
      #3 reset = 1'b0;
      #1;
      chk("arst_la", 32'(la_test), 32'h0);
      chk("arst_lat", 32'(fault_latched), 32'h0);
      chk("arst_val", 32'(first_fault_valid), 32'h0);
      fault_in = '0; lamp_test_req = 1'b0;
      @(negedge clk); reset = 1'b1;
      step(2);
      lamp_test_req = 1'b1;
      count_la("lt_after_rst", LT);
      lamp_test_req = 1'b0; step(2);

      hold = '0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if ((cyc % 200) < 30) hold = '0;
         else
            for (int i = 0; i < N; i++)
               if ($urandom_range(0, 11) == 0) hold[i] = ~hold[i];
         fault_in = hold;
         if ($urandom_range(0, 7) == 0) clear_req = ~clear_req;
         if ($urandom_range(0, 29) == 0) lamp_test_req = ~lamp_test_req;
         if ($urandom_range(0, 599) == 0) begin
            #2 reset = 1'b0;
            @(negedge clk); #2 reset = 1'b1;
         end
      end
      step(2);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
